skinny_sbox8_share_driver: RTL and testbench

Initiator side of the two-share masked SKINNY-128 8-bit S-box interface. It accepts an unmasked byte plus fresh entropy over a valid/ready handshake. It splits the byte into two Boolean shares and drives those shares and the 16-bit refresh randomness into a non-pipelined masked S-box instance (for example, the ISW1 PINI core). It holds all S-box inputs stable for the core latency, then recombines the output shares into an unmasked result on a valid/ready output port. It is used by the round datapath and by the system-level bench as the share/unshare front end of the S-box.

---
 rtl/skinny_sca_pkg.sv | 17 +
 rtl/skinny_sbox8_share_driver.sv | 100 ++++++++++
 tb/tb_skinny_sbox8_share_driver.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/skinny_sca_pkg.sv
// Shared definitions for the masked SKINNY S-box front end: state encoding,
// share/randomness widths and the field layout of the entropy word.
package skinny_sca_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned SHARE_W  = 8;
  localparam int unsigned RND_W    = 16;
  localparam int unsigned MASK_LSB = 0;
  localparam int unsigned R_LSB    = 8;
  localparam int unsigned IN_RND_W = SHARE_W + RND_W;

endpackage

// File: rtl/skinny_sbox8_share_driver.sv
// Two-share front end for a non-pipelined masked SKINNY-8 S-box: splits the
// request byte into Boolean shares, holds them for the core latency, unmasks the result.
module skinny_sbox8_share_driver
  import skinny_sca_pkg::*;
#(
  parameter int unsigned LATENCY = 12,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SHARE_W-1:0]  in_data,
  input  logic [IN_RND_W-1:0] in_rnd,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [SHARE_W-1:0]  sb_in_0,
  output logic [SHARE_W-1:0]  sb_in_1,
  output logic [RND_W-1:0]    sb_r,
  input  logic [SHARE_W-1:0]  sb_out_0,
  input  logic [SHARE_W-1:0]  sb_out_1,
  output logic [SHARE_W-1:0]  out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SHARE_W-1:0] sb0_q, sb0_d;
  logic [SHARE_W-1:0] sb1_q, sb1_d;
  logic [RND_W-1:0]   sbr_q, sbr_d;
  logic [SHARE_W-1:0] dout_q, dout_d;
  logic               in_ready_q, out_valid_q, busy_q;

  // Next-state logic; the plaintext byte only ever reaches a register XOR-masked.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sb0_d   = sb0_q;
    sb1_d   = sb1_q;
    sbr_d   = sbr_q;
    dout_d  = dout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sb0_d   = in_data ^ in_rnd[MASK_LSB +: SHARE_W];
          sb1_d   = in_rnd[MASK_LSB +: SHARE_W];
          sbr_d   = in_rnd[R_LSB +: RND_W];
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          dout_d  = sb_out_0 ^ sb_out_1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake flags are registered copies of the next-state decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sb0_q       <= '0;
      sb1_q       <= '0;
      sbr_q       <= '0;
      dout_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sb0_q       <= sb0_d;
      sb1_q       <= sb1_d;
      sbr_q       <= sbr_d;
      dout_q      <= dout_d;
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_DONE);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sb_in_0   = sb0_q;
  assign sb_in_1   = sb1_q;
  assign sb_r      = sbr_q;
  assign out_data  = dout_q;

endmodule

// File: tb/tb_skinny_sbox8_share_driver.sv
// Directed bench for the share driver, closing the loop through a behavioural
// two-share SKINNY-8 S-box; a LATENCY=1 instance covers the short-latency corner.
module tb_skinny_sbox8_share_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;

  logic [7:0]  in_data = '0, out_data, sb_in_0, sb_in_1, sb_out_0, sb_out_1;
  logic [23:0] in_rnd = '0;
  logic [15:0] sb_r;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy;

  logic [7:0]  in_data1 = '0, out_data1, sb1_in_0, sb1_in_1, sb1_out_0, sb1_out_1;
  logic [23:0] in_rnd1 = '0;
  logic [15:0] sb1_r;
  logic        in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b0, busy1;

  logic [7:0]  exp_q[$];
  logic        mon_en = 1'b0;
  int          n_res = 0;
  int          last_cyc = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] sb_mix(input logic [7:0] v);
    logic [7:0] t;
    t = ((v >> 1) | v) >> 2;
    return ((~t) & 8'h11) ^ v;
  endfunction

  function automatic logic [7:0] sb_perm(input logic [7:0] v);
    return ((v & 8'h01) << 2) | ((v & 8'h06) << 5) | ((v & 8'h20) >> 5) |
           ((v & 8'hC8) >> 2) | ((v & 8'h10) >> 1);
  endfunction

  function automatic logic [7:0] sbox8(input logic [7:0] x);
    logic [7:0] v;
    v = x;
    for (int r = 0; r < 4; r++) begin
      v = sb_mix(v);
      if (r < 3) v = sb_perm(v);
    end
    return (v & 8'hF9) | ((v >> 1) & 8'h02) | ((v << 1) & 8'h04);
  endfunction

  // Masked core model: output shares carry a mask derived from the refresh bits.
  assign sb_out_1  = sb_r[7:0] ^ sb_r[15:8];
  assign sb_out_0  = sbox8(sb_in_0 ^ sb_in_1) ^ sb_out_1;
  assign sb1_out_1 = sb1_r[7:0] ^ sb1_r[15:8];
  assign sb1_out_0 = sbox8(sb1_in_0 ^ sb1_in_1) ^ sb1_out_1;

  skinny_sbox8_share_driver #(.LATENCY(12), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_rnd(in_rnd), .in_valid(in_valid),
    .in_ready(in_ready), .sb_in_0(sb_in_0), .sb_in_1(sb_in_1), .sb_r(sb_r),
    .sb_out_0(sb_out_0), .sb_out_1(sb_out_1), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  skinny_sbox8_share_driver #(.LATENCY(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(in_data1), .in_rnd(in_rnd1), .in_valid(in_valid1),
    .in_ready(in_ready1), .sb_in_0(sb1_in_0), .sb_in_1(sb1_in_1), .sb_r(sb1_r),
    .sb_out_0(sb1_out_0), .sb_out_1(sb1_out_1), .out_data(out_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .busy(busy1)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [23:0] r);
    in_data  = d;
    in_rnd   = r;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 64) begin
      tick();
      lat++;
    end
  endtask

  // Result monitor for the back-to-back sweep, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      check_eq("t3_have_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check_eq("t3_out_data", 32'(out_data), 32'(exp_q.pop_front()));
      if (last_cyc >= 0) check_eq("t3_spacing", 32'(cyc - last_cyc), 32'd14);
      last_cyc = cyc;
      n_res++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [7:0]  e0, e1;
    logic [15:0] er;
    logic        hs;
    int          guard;

    // Reset values, checked while reset is still asserted
    #3;
    check_eq("rst_sb_in_0", 32'(sb_in_0), 32'h0);
    check_eq("rst_sb_in_1", 32'(sb_in_1), 32'h0);
    check_eq("rst_sb_r", 32'(sb_r), 32'h0);
    check_eq("rst_out_data", 32'(out_data), 32'h0);
    check_eq("rst_out_valid", 32'(out_valid), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    #9 rst = 1'b0;
    tick();
    check_eq("rst_in_ready", 32'(in_ready), 32'h1);

    // 1: zero input, zero mask, latency 12
    out_ready = 1'b1;
    send(8'h00, 24'h000000);
    check_eq("t1_sb_in_0", 32'(sb_in_0), 32'h00);
    check_eq("t1_sb_in_1", 32'(sb_in_1), 32'h00);
    check_eq("t1_in_ready", 32'(in_ready), 32'h0);
    check_eq("t1_busy", 32'(busy), 32'h1);
    wait_valid(lat);
    check_eq("t1_latency", 32'(lat), 32'd12);
    check_eq("t1_out_data", 32'(out_data), 32'h65);
    tick();
    check_eq("t1_idle_valid", 32'(out_valid), 32'h0);
    check_eq("t1_idle_ready", 32'(in_ready), 32'h1);

    // 2: result held while the consumer stalls
    out_ready = 1'b0;
    send(8'h01, 24'hA5C35A);
    check_eq("t2_sb_in_0", 32'(sb_in_0), 32'h5B);
    check_eq("t2_sb_in_1", 32'(sb_in_1), 32'h5A);
    check_eq("t2_sb_r", 32'(sb_r), 32'hA5C3);
    wait_valid(lat);
    check_eq("t2_latency", 32'(lat), 32'd12);
    for (int i = 0; i < 5; i++) begin
      check_eq("t2_hold_valid", 32'(out_valid), 32'h1);
      check_eq("t2_hold_data", 32'(out_data), 32'h4C);
      check_eq("t2_hold_in_ready", 32'(in_ready), 32'h0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check_eq("t2_release_valid", 32'(out_valid), 32'h0);
    check_eq("t2_release_ready", 32'(in_ready), 32'h1);
    check_eq("t2_release_busy", 32'(busy), 32'h0);

    // 4: asynchronous reset in WAIT with counter at 5
    send(8'h3C, 24'h123456);
    check_eq("t4_sb_in_0", 32'(sb_in_0), 32'h6A);
    for (int i = 0; i < 6; i++) tick();
    check_eq("t4_counter", 32'(u_dut.cnt_q), 32'd5);
    #2 rst = 1'b1;
    #1;
    check_eq("t4_sb_in_0_rst", 32'(sb_in_0), 32'h0);
    check_eq("t4_sb_in_1_rst", 32'(sb_in_1), 32'h0);
    check_eq("t4_sb_r_rst", 32'(sb_r), 32'h0);
    check_eq("t4_out_data_rst", 32'(out_data), 32'h0);
    check_eq("t4_out_valid_rst", 32'(out_valid), 32'h0);
    check_eq("t4_busy_rst", 32'(busy), 32'h0);
    #1 rst = 1'b0;
    tick();
    check_eq("t4_in_ready_after", 32'(in_ready), 32'h1);
    send(8'h02, 24'h9ABCDE);
    wait_valid(lat);
    check_eq("t4_latency", 32'(lat), 32'd12);
    check_eq("t4_out_data", 32'(out_data), 32'h6A);
    tick();

    // 5: inputs churn during WAIT, shares stay frozen
    out_ready = 1'b0;
    send(8'hC3, 24'h0F1E2D);
    e0 = 8'hC3 ^ 8'h2D;
    e1 = 8'h2D;
    er = 16'h0F1E;
    guard = 0;
    while (!out_valid && guard < 64) begin
      in_data  = 8'($urandom);
      in_rnd   = 24'($urandom);
      in_valid = 1'($urandom);
      tick();
      guard++;
      check_eq("t5_sb_in_0", 32'(sb_in_0), 32'(e0));
      check_eq("t5_sb_in_1", 32'(sb_in_1), 32'(e1));
      check_eq("t5_sb_r", 32'(sb_r), 32'(er));
    end
    in_valid = 1'b0;
    check_eq("t5_latency", 32'(guard), 32'd12);
    check_eq("t5_out_data", 32'(out_data), 32'(sbox8(8'hC3)));
    out_ready = 1'b1;
    tick();
    check_eq("t5_release_valid", 32'(out_valid), 32'h0);

    // 3: full byte sweep, in_valid held high back-to-back
    mon_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_data  = 8'(i);
      in_rnd   = 24'($urandom);
      in_valid = 1'b1;
      guard = 0;
      do begin
        hs = in_ready;
        tick();
        guard++;
      end while (!hs && guard < 64);
      check_eq("t3_accept", 32'(hs), 32'h1);
      exp_q.push_back(sbox8(8'(i)));
    end
    in_valid = 1'b0;
    guard = 0;
    while (n_res < 256 && guard < 100) begin
      tick();
      guard++;
    end
    mon_en = 1'b0;
    check_eq("t3_result_count", 32'(n_res), 32'd256);
    check_eq("t3_queue_empty", 32'(exp_q.size()), 32'd0);
    check_eq("t3_sbox_ff", 32'(sbox8(8'hFF)), 32'hFF);

    // 6: LATENCY = 1 instance
    out_ready1 = 1'b1;
    in_data1   = 8'h02;
    in_rnd1    = 24'h778899;
    in_valid1  = 1'b1;
    tick();
    in_valid1  = 1'b0;
    check_eq("t6_sb_in_0", 32'(sb1_in_0), 32'(8'h02 ^ 8'h99));
    check_eq("t6_valid_early", 32'(out_valid1), 32'h0);
    lat = 0;
    while (!out_valid1 && lat < 16) begin
      tick();
      lat++;
    end
    check_eq("t6_latency", 32'(lat), 32'd1);
    check_eq("t6_out_data", 32'(out_data1), 32'h6A);
    tick();
    check_eq("t6_idle", 32'(in_ready1), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
